pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 3-stage RV32I pipeline (fetch, decode/execute, memory/writeback).
- Stalls the whole pipeline while a load/store in the writeback buffer waits on the data memory req/ack handshake.
- Redirects the PC and injects bubbles into the execute instruction buffer after a taken branch or jump.
- Keeps saturating stall/flush performance counters.
- Sits beside the forwarding logic and drives the PC mux and the enables of both instruction buffers.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: memory-handshake stalls, branch/jump redirect
// with bubble injection, memory-timeout trap, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir_ex,
    input  logic [31:0] ir_wb,
    input  logic        br_taken,
    input  logic        dmem_ack,
    input  logic        cnt_clr,
    output logic        dmem_req,
    output logic        stall,
    output logic        pc_sel,
    output logic        flush_ex,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WAIT_W = 16;
    localparam int unsigned LEFT_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [LEFT_W-1:0] LEFT_INIT  = LEFT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH,
        ST_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LEFT_W-1:0]   flush_left_q, flush_left_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                mem_err_q, mem_err_d;

    logic wb_mem;
    logic ex_redirect;
    logic unused_ok;

    // Only the opcode fields matter here; the bubble word is owned by the buffer mux.
    assign unused_ok = ^{ir_wb[31:7], ir_ex[31:7], NOP_INSTR};

    always_comb begin
        wb_mem      = (ir_wb[6:0] == OP_LOAD) || (ir_wb[6:0] == OP_STORE);
        ex_redirect = (ir_ex[6:0] == OP_JAL) || (ir_ex[6:0] == OP_JALR) ||
                      ((ir_ex[6:0] == OP_BRANCH) && br_taken);
    end

    // Next-state and control outputs; stall always overrides redirect/flush.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_left_d = flush_left_q;
        mem_err_d    = mem_err_q;
        pc_sel       = 1'b0;
        flush_ex     = 1'b0;

        dmem_req = wb_mem && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT));
        stall    = (dmem_req && !dmem_ack) || (state_q == ST_ERROR);

        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (ex_redirect) begin
                    pc_sel   = 1'b1;
                    flush_ex = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d      = ST_FLUSH;
                        flush_left_d = LEFT_INIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    flush_ex     = 1'b1;
                    flush_left_d = flush_left_q - LEFT_W'(1);
                    if (flush_left_q == LEFT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_ERROR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating counters; clear beats increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (pc_sel && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            flush_left_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FLUSH_DEPTH = 2;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] LW   = 32'h00002083;
    localparam logic [31:0] SW   = 32'h00102023;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] JAL  = 32'h0080006f;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [6:0] WB_OPS [8] = '{7'h03, 7'h03, 7'h23, 7'h23, 7'h33, 7'h13, 7'h37, 7'h6f};
    localparam logic [6:0] EX_OPS [8] = '{7'h6f, 7'h67, 7'h63, 7'h63, 7'h33, 7'h13, 7'h03, 7'h23};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir_ex = NOP;
    logic [31:0] ir_wb = NOP;
    logic        br_taken = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        dmem_req, stall, pc_sel, flush_ex, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [4:0]  outs;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    pipe_hazard_ctrl #(
        .FLUSH_DEPTH(FLUSH_DEPTH),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_ex    (ir_ex),
        .ir_wb    (ir_wb),
        .br_taken (br_taken),
        .dmem_ack (dmem_ack),
        .cnt_clr  (cnt_clr),
        .dmem_req (dmem_req),
        .stall    (stall),
        .pc_sel   (pc_sel),
        .flush_ex (flush_ex),
        .mem_err  (mem_err),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {dmem_req, stall, pc_sel, flush_ex, mem_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ex, input logic [31:0] wb,
                         input logic bt, input logic ack, input logic clr);
        ir_ex    = ex;
        ir_wb    = wb;
        br_taken = bt;
        dmem_ack = ack;
        cnt_clr  = clr;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (outs !== 5'b00000) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b00000); end
        checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnts got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        drive(NOP, LW, 1'b0, 1'b1, 1'b0);
        checks++; if (outs !== 5'b10000) begin errors++; $display("FAIL zero_wait_outs got=%b exp=%b", outs, 5'b10000); end
        tick();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00000) begin errors++; $display("FAIL zero_wait_after got=%b exp=%b", outs, 5'b00000); end
        checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL zero_wait_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
    endtask

    task automatic test_store_wait();
        for (int i = 0; i < 3; i++) begin
            drive(NOP, SW, 1'b0, 1'b0, 1'b0);
            checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL store_wait_c%0d got=%b exp=%b", i, outs, 5'b11000); end
            tick();
            exp_sc++;
        end
        drive(NOP, SW, 1'b0, 1'b1, 1'b0);
        checks++; if (outs !== 5'b10000) begin errors++; $display("FAIL store_ack got=%b exp=%b", outs, 5'b10000); end
        tick();
        drive(JAL, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00110) begin errors++; $display("FAIL store_back_in_run got=%b exp=%b", outs, 5'b00110); end
        checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL store_stall_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
        tick();
        exp_fc++;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00010) begin errors++; $display("FAIL store_jal_bubble got=%b exp=%b", outs, 5'b00010); end
        tick();
    endtask

    task automatic test_branch();
        drive(BEQ, NOP, 1'b1, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00110) begin errors++; $display("FAIL beq_taken got=%b exp=%b", outs, 5'b00110); end
        tick();
        exp_fc++;
        drive(JAL, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00010) begin errors++; $display("FAIL beq_second_bubble got=%b exp=%b", outs, 5'b00010); end
        checks++; if (flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL beq_flush_cnt got=%0d exp=%0d", flush_cnt, exp_fc); end
        tick();
        drive(BEQ, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00000) begin errors++; $display("FAIL beq_not_taken got=%b exp=%b", outs, 5'b00000); end
        checks++; if (flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL flush_ignored_jal got=%0d exp=%0d", flush_cnt, exp_fc); end
        tick();
        drive(JALR, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00110) begin errors++; $display("FAIL jalr got=%b exp=%b", outs, 5'b00110); end
        tick();
        exp_fc++;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp [5] = '{5'b00110, 5'b00010, 5'b00110, 5'b00010, 5'b00000};
        logic [31:0] ex [5] = '{JAL, JAL, JAL, NOP, NOP};
        for (int i = 0; i < 5; i++) begin
            drive(ex[i], NOP, 1'b0, 1'b0, 1'b0);
            checks++; if (outs !== exp[i]) begin errors++; $display("FAIL b2b_c%0d got=%b exp=%b", i, outs, exp[i]); end
            tick();
        end
        exp_fc += 2;
        checks++; if (flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL b2b_flush_cnt got=%0d exp=%0d", flush_cnt, exp_fc); end
    endtask

    task automatic test_redirect_during_stall();
        for (int i = 0; i < 2; i++) begin
            drive(JAL, LW, 1'b0, 1'b0, 1'b0);
            checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL jal_stall_c%0d got=%b exp=%b", i, outs, 5'b11000); end
            tick();
            exp_sc++;
        end
        drive(JAL, LW, 1'b0, 1'b1, 1'b0);
        checks++; if (outs !== 5'b10000) begin errors++; $display("FAIL jal_ack_cycle got=%b exp=%b", outs, 5'b10000); end
        tick();
        drive(JAL, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00110) begin errors++; $display("FAIL jal_after_ack got=%b exp=%b", outs, 5'b00110); end
        tick();
        exp_fc++;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (outs !== 5'b00010) begin errors++; $display("FAIL jal_after_bubble got=%b exp=%b", outs, 5'b00010); end
        checks++; if (stall_cnt !== 16'(exp_sc) || flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL jal_stall_cnts got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_sc, exp_fc); end
        tick();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            drive(JAL, LW, 1'b0, 1'b0, 1'b0);
            checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL timeout_wait_c%0d got=%b exp=%b", i, outs, 5'b11000); end
            tick();
            exp_sc++;
        end
        drive(JAL, LW, 1'b0, 1'b1, 1'b0);
        checks++; if (outs !== 5'b01001) begin errors++; $display("FAIL timeout_error got=%b exp=%b", outs, 5'b01001); end
        tick();
        exp_sc++;
        drive(JAL, LW, 1'b0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL timeout_stall_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (outs !== 5'b00000 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin errors++; $display("FAIL async_reset got=%b %h %h exp=00000 0 0", outs, stall_cnt, flush_cnt); end
        #2;
        rst_n = 1'b1;
        exp_sc = 0;
        exp_fc = 0;
        tick();
        drive(NOP, LW, 1'b0, 1'b1, 1'b0);
        checks++; if (outs !== 5'b10000) begin errors++; $display("FAIL run_after_reset got=%b exp=%b", outs, 5'b10000); end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            drive(NOP, LW, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        repeat (65540) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF || outs !== 5'b01001) begin errors++; $display("FAIL sat_reach got=%h %b exp=ffff 01001", stall_cnt, outs); end
        tick();
        tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
        tick();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin errors++; $display("FAIL clr_wins got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'h1) begin errors++; $display("FAIL count_after_clr got=%h exp=1", stall_cnt); end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Reference: tracks how long the current request has waited, how many
    // bubbles remain, and whether the trap has fired.
    task automatic test_random();
        int m_err = 0, m_wait = 0, m_frem = 0, m_sc = 0, m_fc = 0, err_cyc = 0;
        logic [6:0] op_wb, op_ex;
        logic bt, ack, clr, is_mem, redir;
        logic e_req, e_stall, e_pc, e_fl;
        logic [4:0] e_outs;
        for (int n = 0; n < 3000; n++) begin
            op_wb = WB_OPS[$urandom_range(0, 7)];
            op_ex = EX_OPS[$urandom_range(0, 7)];
            bt    = 1'($urandom);
            clr   = ($urandom_range(0, 31) == 0);
            ack   = ($urandom_range(0, 2) != 0);
            if (m_wait >= 3 && $urandom_range(0, 7) != 0) ack = 1'b1;
            drive({25'($urandom), op_ex}, {25'($urandom), op_wb}, bt, ack, clr);

            is_mem = (op_wb == 7'h03) || (op_wb == 7'h23);
            redir  = (op_ex == 7'h6f) || (op_ex == 7'h67) || (op_ex == 7'h63 && bt);
            if (m_err != 0) begin
                e_req = 0; e_stall = 1; e_pc = 0; e_fl = 0;
            end else if (m_frem > 0) begin
                e_req = 0; e_stall = 0; e_pc = 0; e_fl = 1;
            end else begin
                e_req   = is_mem;
                e_stall = is_mem && !ack;
                e_pc    = !e_stall && (m_wait == 0) && redir;
                e_fl    = e_pc;
            end
            e_outs = {e_req, e_stall, e_pc, e_fl, (m_err != 0)};
            checks++; if (outs !== e_outs) begin errors++; $display("FAIL rand_outs n=%0d got=%b exp=%b", n, outs, e_outs); end
            checks++; if (stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc)) begin errors++; $display("FAIL rand_cnts n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, m_sc, m_fc); end

            if (clr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (e_stall && m_sc < 65535) m_sc++;
                if (e_pc && m_fc < 65535) m_fc++;
            end
            if (m_err == 0) begin
                if (m_frem > 0) m_frem--;
                else if (e_stall) begin
                    m_wait++;
                    if (m_wait == int'(MEM_TIMEOUT)) m_err = 1;
                end else begin
                    m_wait = 0;
                    if (e_pc) m_frem = int'(FLUSH_DEPTH) - 1;
                end
            end
            tick();

            if (m_err != 0) begin
                err_cyc++;
                if (err_cyc == 5) begin
                    rst_n = 1'b0;
                    #2;
                    rst_n = 1'b1;
                    m_err = 0; m_wait = 0; m_frem = 0; m_sc = 0; m_fc = 0; err_cyc = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_store_wait();
        test_branch();
        test_back_to_back();
        test_redirect_during_stall();
        test_timeout();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
